// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous-read RAM port between N_REQ
// requesters, issuing one registered access per clock. Read data is routed
// back to the issuing requester through a tag pipeline matching RAM latency.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins
// priority (lock and burst limiting removed); default is round-robin with
// burst lock.
module ram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int N_REQ     = 3,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         we_i,
  input  logic [N_REQ-1:0]         lock_i,
  input  logic [N_REQ*ADDR_W-1:0]  addr_i,
  input  logic [N_REQ*DATA_W-1:0]  wdata_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [N_REQ-1:0]         rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_data,
  output logic                     ram_wren,
  input  logic [DATA_W-1:0]        ram_q
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Unpacked views of the packed request buses
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  // Arbitration state and decision
  logic [IDX_W-1:0] owner_reg;
  logic [IDX_W-1:0] owner_next;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             gnt_any;
  int               search_pos;

  // Tag pipeline: one entry per cycle of RAM read latency, then the output stage
  logic             tag_valid_reg [RD_LAT];
  logic [IDX_W-1:0] tag_idx_reg   [RD_LAT];
  logic [N_REQ-1:0] ret_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
      // Grant is suppressed while reset is asserted
      assign gnt_o[gi]      = gnt_any && !rst && (gnt_idx == IDX_W'(gi));
      assign ret_onehot[gi] = tag_valid_reg[RD_LAT-1] && (tag_idx_reg[RD_LAT-1] == IDX_W'(gi));
    end
  endgenerate

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Lock inputs and the burst limit have no meaning in fixed-priority mode
  logic unused_cfg;
  assign unused_cfg = ^{lock_i, 32'(MAX_BURST)};

  // Fixed priority: lowest requesting index wins; owner kept for debug
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = owner_reg;
    owner_next = owner_reg;
    search_pos = 0;
    cand       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      search_pos = i;
      cand       = IDX_W'(search_pos);
      if (req_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) begin
      owner_next = gnt_idx;
    end
  end

  // Owner register
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg <= IDX_W'(N_REQ - 1);
    end else begin
      owner_reg <= owner_next;
    end
  end
`else
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic [CNT_W-1:0] burst_cnt_reg;
  logic [CNT_W-1:0] burst_cnt_next;
  logic             locked_reg;
  logic             locked_next;

  // Round-robin with burst lock: a locked owner keeps the port until it
  // drops lock/req or uses up MAX_BURST grants; otherwise search from owner+1.
  // The search covers owner last, so a lone requester at its limit is
  // re-granted with a fresh burst count.
  always_comb begin
    gnt_any        = 1'b0;
    gnt_idx        = owner_reg;
    owner_next     = owner_reg;
    burst_cnt_next = burst_cnt_reg;
    search_pos     = 0;
    cand           = '0;
    if (locked_reg && req_i[owner_reg] && (burst_cnt_reg < CNT_W'(MAX_BURST - 1))) begin
      gnt_any        = 1'b1;
      burst_cnt_next = burst_cnt_reg + CNT_W'(1);
    end else begin
      // Walk offsets from far to near so the nearest requester wins
      for (int i = N_REQ; i >= 1; i--) begin
        search_pos = int'(owner_reg) + i;
        if (search_pos >= N_REQ) begin
          search_pos = search_pos - N_REQ;
        end
        cand = IDX_W'(search_pos);
        if (req_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
      if (gnt_any) begin
        owner_next     = gnt_idx;
        burst_cnt_next = '0;
      end
    end
    locked_next = gnt_any && lock_i[gnt_idx];
  end

  // Owner, burst counter and lock-continuation flag
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg     <= IDX_W'(N_REQ - 1);
      burst_cnt_reg <= '0;
      locked_reg    <= 1'b0;
    end else begin
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      locked_reg    <= locked_next;
    end
  end
`endif

  // Issue stage: register the granted access onto the RAM port
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
    end else if (gnt_any) begin
      ram_addr <= addr_arr[gnt_idx];
      ram_data <= wdata_arr[gnt_idx];
      ram_wren <= we_i[gnt_idx];
    end else begin
      ram_wren <= 1'b0;
    end
  end

  // Tag stage 0: remember which requester issued a read this cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_reg[0] <= 1'b0;
      tag_idx_reg[0]   <= '0;
    end else begin
      tag_valid_reg[0] <= gnt_any && !we_i[gnt_idx];
      tag_idx_reg[0]   <= gnt_idx;
    end
  end

  generate
    for (gi = 1; gi < RD_LAT; gi++) begin : g_tag
      // Tag stage gi: advance tags in step with the RAM read pipeline
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_valid_reg[gi] <= 1'b0;
          tag_idx_reg[gi]   <= '0;
        end else begin
          tag_valid_reg[gi] <= tag_valid_reg[gi-1];
          tag_idx_reg[gi]   <= tag_idx_reg[gi-1];
        end
      end
    end
  endgenerate

  // Output stage: capture RAM data and flag the owning requester
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_o <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= ret_onehot;
      if (tag_valid_reg[RD_LAT-1]) begin
        rdata_o <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// behavioural model (arbitration rules, shadow memory, return queue).
// Honours RAM_ARB_FIXED_PRIO_EN for the fixed-priority build.
module tb_ram_port_arbiter;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int N_REQ     = 3;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_REQ-1:0]        req_bus = '0;
  logic [N_REQ-1:0]        we_bus = '0;
  logic [N_REQ-1:0]        lock_bus = '0;
  logic [N_REQ*ADDR_W-1:0] addr_bus = '0;
  logic [N_REQ*DATA_W-1:0] wdata_bus = '0;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        rvalid_o;
  logic [DATA_W-1:0]       rdata_o;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_data;
  logic                    ram_wren;
  logic [DATA_W-1:0]       ram_q;

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_REQ(N_REQ),
    .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req_i(req_bus), .we_i(we_bus), .lock_i(lock_bus),
    .addr_i(addr_bus), .wdata_i(wdata_bus),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Preload pattern of the pixel RAM
  function automatic logic [DATA_W-1:0] init_val(input int a);
    if (a == 2) return 8'hA5;
    return DATA_W'(a) ^ 8'h5A;
  endfunction

  // Pixel RAM: one-cycle synchronous read on registered address
  logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_q_reg;
  assign ram_q = ram_q_reg;
  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) ram_mem[a] = init_val(a);
  end
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_q_reg <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [N_REQ-1:0] v, input int i);
    return ((v >> i) & N_REQ'(1)) != '0;
  endfunction

  // ---------------- Behavioural model ----------------
  typedef struct {
    int                due;
    int                k;
    logic [DATA_W-1:0] d;
  } ret_t;

  ret_t              retq[$];
  logic [DATA_W-1:0] shadow [int];
  int                cyc = 0;
  int                m_owner = N_REQ - 1;
  int                m_cnt = 0;
  bit                m_locked = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_wren = 1'b0;
  logic [N_REQ-1:0]  m_rvalid = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic [N_REQ-1:0]  gnt_seen = '0;
  int                exp_g;
  bit                cont;
  logic [N_REQ-1:0]  exp_gnt;
  logic [ADDR_W-1:0] ga;
  ret_t              r;

  function automatic logic [DATA_W-1:0] mem_read(input int a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  // Compare process: check this cycle's outputs, then advance the model
  always @(negedge clk) begin
    exp_g = -1;
    cont  = 1'b0;
    if (!rst) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      for (int i = N_REQ - 1; i >= 0; i--) if (bit_of(req_bus, i)) exp_g = i;
`else
      if (m_locked && bit_of(req_bus, m_owner) && m_cnt < MAX_BURST - 1) begin
        exp_g = m_owner;
        cont  = 1'b1;
      end else begin
        for (int i = 1; i <= N_REQ; i++)
          if (exp_g < 0 && bit_of(req_bus, (m_owner + i) % N_REQ)) exp_g = (m_owner + i) % N_REQ;
      end
`endif
    end
    exp_gnt = (exp_g < 0) ? '0 : (N_REQ'(1) << exp_g);

    chk("gnt", gnt_o, exp_gnt);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_data", ram_data, m_data);
    chk("ram_wren", ram_wren, m_wren);
    chk("rvalid", rvalid_o, m_rvalid);
    chk("rdata", rdata_o, m_rdata);
    if (m_rvalid != '0)
      $display("cycle %0d: read return rvalid=%b data=%02h", cyc, m_rvalid, m_rdata);
    gnt_seen = gnt_o;

    if (rst) begin
      retq.delete();
      m_owner = N_REQ - 1; m_cnt = 0; m_locked = 1'b0;
      m_addr = '0; m_data = '0; m_wren = 1'b0;
      m_rvalid = '0; m_rdata = '0;
    end else begin
      if (exp_g >= 0) begin
        ga     = addr_bus[exp_g*ADDR_W +: ADDR_W];
        m_addr = ga;
        m_data = wdata_bus[exp_g*DATA_W +: DATA_W];
        m_wren = bit_of(we_bus, exp_g);
        if (m_wren) begin
          shadow[int'(ga)] = m_data;
        end else begin
          r.due = cyc + RD_LAT + 1;
          r.k   = exp_g;
          r.d   = mem_read(int'(ga));
          retq.push_back(r);
        end
        if (cont) m_cnt++;
        else begin
          m_owner = exp_g;
          m_cnt   = 0;
        end
        m_locked = bit_of(lock_bus, exp_g);
      end else begin
        m_wren   = 1'b0;
        m_locked = 1'b0;
      end
      m_rvalid = '0;
      if (retq.size() > 0 && retq[0].due == cyc + 1) begin
        m_rvalid = N_REQ'(1) << retq[0].k;
        m_rdata  = retq[0].d;
        void'(retq.pop_front());
      end
    end
    cyc++;
  end

  // ---------------- Stimulus ----------------
  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin();
      req_bus = '0; lock_bus = '0; we_bus = '0;
    end
  endtask

  task automatic set_acc(input int k, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    addr_bus[k*ADDR_W +: ADDR_W]  = a;
    wdata_bus[k*DATA_W +: DATA_W] = d;
    we_bus[k] = we;
  endtask

  logic [N_REQ-1:0] exp_first [4];
  logic [N_REQ-1:0] busy = '0;

  initial begin
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_first[0] = 3'b001; exp_first[1] = 3'b001; exp_first[2] = 3'b001; exp_first[3] = 3'b001;
`else
    exp_first[0] = 3'b001; exp_first[1] = 3'b010; exp_first[2] = 3'b100; exp_first[3] = 3'b001;
`endif
    // Reset, with requests present to confirm grants are blocked
    rst = 1'b1;
    req_bus = 3'b111;
    for (int i = 0; i < 2; i++) begin
      cyc_begin();
      @(negedge clk);
      chk("rst_gnt", gnt_o, 3'b000);
      chk("rst_rvalid", rvalid_o, 3'b000);
      chk("rst_rdata", rdata_o, 8'h00);
      chk("rst_ram_addr", ram_addr, 16'h0000);
      chk("rst_ram_wren", ram_wren, 1'b0);
    end

    // First grants after reset
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      rst = 1'b0;
      req_bus = 3'b111; we_bus = 3'b000;
      set_acc(0, 1'b0, 16'h0100, 8'h00);
      set_acc(1, 1'b0, 16'h0101, 8'h00);
      set_acc(2, 1'b0, 16'h0102, 8'h00);
      @(negedge clk);
      chk("first_gnt", gnt_o, 32'(exp_first[i]));
    end
    idle(6);

    // Read latency: requester 1 reads address 2
    cyc_begin();
    req_bus = 3'b010; set_acc(1, 1'b0, 16'h0002, 8'h00);
    @(negedge clk); chk("lat_gnt", gnt_o, 3'b010);
    cyc_begin(); req_bus = '0;
    @(negedge clk); chk("lat_addr", ram_addr, 16'h0002); chk("lat_rv1", rvalid_o, 3'b000);
    cyc_begin();
    @(negedge clk); chk("lat_rv2", rvalid_o, 3'b000);
    cyc_begin();
    @(negedge clk); chk("lat_rv3", rvalid_o, 3'b010); chk("lat_data", rdata_o, 8'hA5);
    cyc_begin();
    @(negedge clk); chk("lat_rv4", rvalid_o, 3'b000);
    idle(3);

    // Write then read the same address back-to-back from requester 2
    cyc_begin();
    req_bus = 3'b100; set_acc(2, 1'b1, 16'h0010, 8'h3C);
    @(negedge clk); chk("wr_gnt", gnt_o, 3'b100);
    cyc_begin();
    set_acc(2, 1'b0, 16'h0010, 8'h00);
    @(negedge clk); chk("rd_gnt", gnt_o, 3'b100); chk("wr_wren1", ram_wren, 1'b1);
    cyc_begin(); req_bus = '0;
    @(negedge clk); chk("wr_wren2", ram_wren, 1'b0);
    cyc_begin();
    @(negedge clk); chk("wr_rv", rvalid_o, 3'b000);
    cyc_begin();
    @(negedge clk); chk("wr_rv_back", rvalid_o, 3'b100); chk("wr_data_back", rdata_o, 8'h3C);
    idle(4);

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 1 always beats requester 2
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      req_bus = 3'b110; lock_bus = 3'b000;
      set_acc(1, 1'b0, 16'h0020, 8'h00);
      set_acc(2, 1'b0, 16'h0021, 8'h00);
      @(negedge clk); chk("fixed_gnt", gnt_o, 3'b010);
    end
`else
    // Burst lock: requester 0 locked while requester 1 waits
    for (int i = 0; i < MAX_BURST + 1; i++) begin
      cyc_begin();
      req_bus = 3'b011; lock_bus = 3'b001;
      set_acc(0, 1'b0, 16'(16'h0040 + i), 8'h00);
      set_acc(1, 1'b0, 16'h0050, 8'h00);
      @(negedge clk);
      if (i < MAX_BURST) chk("burst_gnt0", gnt_o, 3'b001);
      else chk("burst_gnt1", gnt_o, 3'b010);
    end
`endif
    idle(5);

    // Reset during in-flight reads: no returns may appear
    cyc_begin();
    req_bus = 3'b001; set_acc(0, 1'b0, 16'h0003, 8'h00);
    @(negedge clk); chk("mid_gnt0", gnt_o, 3'b001);
    cyc_begin();
    req_bus = 3'b010; set_acc(1, 1'b0, 16'h0004, 8'h00);
    @(negedge clk); chk("mid_gnt1", gnt_o, 3'b010);
    cyc_begin();
    rst = 1'b1; req_bus = 3'b111;
    @(negedge clk); chk("mid_rst_gnt", gnt_o, 3'b000); chk("mid_rv0", rvalid_o, 3'b000);
    cyc_begin();
    rst = 1'b0;
    @(negedge clk); chk("mid_post_gnt", gnt_o, 3'b001); chk("mid_rv1", rvalid_o, 3'b000);
    cyc_begin(); req_bus = '0;
    @(negedge clk); chk("mid_rv2", rvalid_o, 3'b000);
    cyc_begin();
    @(negedge clk); chk("mid_rv3", rvalid_o, 3'b000);
    idle(4);

    // Randomized traffic obeying the requester hold rules
    busy = '0;
    for (int n = 0; n < 1500; n++) begin
      cyc_begin();
      rst = ($urandom_range(0, 399) == 0);
      for (int k = 0; k < N_REQ; k++) begin
        if (busy[k] && gnt_seen[k]) busy[k] = 1'b0;
        if (!busy[k] && $urandom_range(0, 99) < 50) begin
          busy[k] = 1'b1;
          set_acc(k, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
        end
        req_bus[k]  = busy[k];
        lock_bus[k] = busy[k] && ($urandom_range(0, 2) == 0);
      end
    end
    rst = 1'b0;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
